shift_right_seq: RTL



---
 rtl/shift_right_seq.sv | 120 ++++++++++++
 1 files changed

// File: rtl/shift_right_seq.sv
// Iterative right shifter (SRL/SRA): one log2 stage per clock, constant latency of
// clog2(data_length)+1 cycles from accept to the done pulse.
module shift_right_seq #(
    parameter int unsigned data_length = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           arith,
    input  logic [$clog2(data_length)-1:0] shift,
    input  logic [data_length-1:0]         B,
    output logic                           ready,
    output logic                           done,
    output logic [data_length-1:0]         H
);

    localparam int unsigned DW = data_length;
    localparam int unsigned L  = $clog2(data_length);
    localparam int unsigned SW = L + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   work_q, work_d;
    logic [L-1:0]    amt_q, amt_d;
    logic            fill_q, fill_d;
    logic [L-1:0]    j_q, j_d;
    logic [DW-1:0]   h_q, h_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;

    logic [SW-1:0]   stride_c;
    logic [DW-1:0]   shifted_c;
    logic [DW-1:0]   fill_mask_c;
    logic [DW-1:0]   stage_c;

    // Single shared stage: shift by 2^j when amount bit j is set, filling from the top.
    always_comb begin
        stride_c    = SW'(1) << j_q;
        shifted_c   = work_q >> stride_c;
        fill_mask_c = ~({DW{1'b1}} >> stride_c);
        stage_c     = work_q;
        if (amt_q[j_q]) begin
            stage_c = fill_q ? (shifted_c | fill_mask_c) : shifted_c;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        amt_d   = amt_q;
        fill_d  = fill_q;
        j_d     = j_q;
        h_d     = h_q;
        ready_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    work_d  = B;
                    amt_d   = shift;
                    fill_d  = arith & B[DW-1];
                    j_d     = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            SHIFT: begin
                work_d = stage_c;
                if (j_q == L'(L - 1)) begin
                    h_d     = stage_c;
                    j_d     = '0;
                    state_d = DONE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    j_d = j_q + L'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            amt_q   <= '0;
            fill_q  <= 1'b0;
            j_q     <= '0;
            h_q     <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            amt_q   <= amt_d;
            fill_q  <= fill_d;
            j_q     <= j_d;
            h_q     <= h_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign H     = h_q;

endmodule
